inst_mem_resp: RTL

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp_pkg.sv | 18 +
 rtl/inst_ram_1r1w.sv | 51 +++++
 rtl/inst_mem_resp.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: shared constants for the instruction-memory responder.
// Holds the 2-bit FSM state encoding and the legal LATENCY range.
// Imported by inst_mem_resp and inst_ram_1r1w.
package inst_mem_resp_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Legal range of the LATENCY parameter
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;

  // The down-counter holds at most LATENCY_MAX-1
  localparam int CNT_W = $clog2(LATENCY_MAX);

endpackage

// File: rtl/inst_ram_1r1w.sv
// inst_ram_1r1w: synchronous word array, one read port and one write port.
// Latency: read data is registered on the edge where re is high; it holds otherwise.
// Backpressure: none; a read and a write to the same word in one cycle return the old word.
// Ports: clk, rst (clears only the read register, never the array),
//        re/raddr/rdata read port, we/waddr/wdata write port.
module inst_ram_1r1w
  import inst_mem_resp_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // The array reads the pre-write value because both updates land on the same edge.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction memory with a fixed-latency fetch response.
// Latency: request accepted in cycle T returns inst_data_ok in cycle T+LATENCY.
// Backpressure: one request outstanding; inst_addr_ok stays low until the FSM is back in IDLE.
// Ports: clk, rst (sync, active-high); inst_req/inst_addr/inst_addr_ok fetch request;
//        inst_rdata/inst_data_ok fetch response; ld_en/ld_addr/ld_data backdoor word load.
// Optional: define INST_ADDR_ERR_EN to add inst_adderr, flagging a misaligned fetch
//           (the returned word is then forced to 0).
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
`ifdef INST_ADDR_ERR_EN
  ,
  output logic        inst_adderr
`endif
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  data_ok_q, data_ok_d;

  logic                  hs;
  logic                  resp_enter;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           ram_rdata;

  // Upper address bits are intentionally ignored (aliasing); byte-lane bits
  // are ignored unless the misalignment check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr, ld_addr};

  assign inst_addr_ok = (state_q == ST_IDLE) && !rst;
  assign hs           = inst_req && inst_addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          idx_d   = inst_addr[DEPTH_LOG2+1:2];
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        // Leave when the counter is about to hit 0 so RESP lands on T+LATENCY.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign resp_enter = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign data_ok_d  = resp_enter;

  // With LATENCY=1 RESP is entered straight from IDLE, before idx_q is loaded,
  // so the read index is taken directly from the request in that case.
  assign rd_idx = (state_q == ST_IDLE) ? inst_addr[DEPTH_LOG2+1:2] : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_ok_q <= data_ok_d;
    end
  end

  inst_ram_1r1w #(
    .AW (DEPTH_LOG2),
    .DW (32)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (resp_enter && !rst),
    .raddr (rd_idx),
    .rdata (ram_rdata),
    .we    (ld_en && !rst),
    .waddr (ld_addr[DEPTH_LOG2+1:2]),
    .wdata (ld_data)
  );

  assign inst_data_ok = data_ok_q;

`ifdef INST_ADDR_ERR_EN
  logic [1:0] lsb_q, lsb_d;
  logic [1:0] rd_lsb;
  logic       adderr_q, adderr_d;

  assign lsb_d    = hs ? inst_addr[1:0] : lsb_q;
  assign rd_lsb   = (state_q == ST_IDLE) ? inst_addr[1:0] : lsb_q;
  assign adderr_d = resp_enter ? (rd_lsb != 2'b00) : adderr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q    <= '0;
      adderr_q <= 1'b0;
    end else begin
      lsb_q    <= lsb_d;
      adderr_q <= adderr_d;
    end
  end

  assign inst_adderr = adderr_q;
  // adderr_q is held with the data, so the forced zero also holds between responses.
  assign inst_rdata  = adderr_q ? 32'h0 : ram_rdata;
`else
  assign inst_rdata  = ram_rdata;
`endif

endmodule
